// File: rtl/cpu7_inst_resp.sv
// Fixed-latency instruction fetch responder for cpu7: stands in for the icache,
// reading 128-bit lines from a local SRAM and returning them in request order.
module cpu7_inst_resp #(
  parameter int          RAM_LAT  = 2,
  parameter int          MEM_AW   = 14,
  parameter logic [31:0] MEM_BASE = 32'h1c000000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic [31:0]       inst_addr,
  input  logic              inst_cancel,
  output logic              inst_addr_ok,
  output logic [127:0]      inst_rdata,
  output logic              inst_valid,
  output logic [1:0]        inst_count,
  output logic              inst_uncache,
  output logic              inst_exception,
  output logic [5:0]        inst_exccode,
  output logic              ram_en,
  output logic [MEM_AW-1:0] ram_addr,
  input  logic [127:0]      ram_rdata
);

  typedef struct packed {
    logic       kill;
    logic       bad;
    logic [1:0] wsel;
  } trk_t;

  localparam logic [31:0] LIMIT   = 32'd1 << (MEM_AW + 4);
  localparam logic [5:0]  EXC_ADEF = 6'h08;

  logic [31:0]             off;
  logic                    bad;
  logic [RAM_LAT:1]        vld_pipe;
  trk_t [RAM_LAT:1]        trk_pipe;
  trk_t [RAM_LAT:1]        trk_nxt;
  trk_t                    last;
  logic                    load;

  // Address screening happens in the accept cycle so bad fetches never touch the SRAM
  assign off          = inst_addr - MEM_BASE;
  assign bad          = (|inst_addr[1:0]) | (inst_addr < MEM_BASE) | (off >= LIMIT);
  assign inst_addr_ok = inst_req & ~inst_cancel & resetn;
  assign ram_en       = inst_addr_ok & ~bad;
  assign ram_addr     = off[MEM_AW+3:4];
  assign inst_uncache = 1'b0;

  // A cancel marks everything in flight; killed entries still drain so ordering is kept
  always_comb begin
    trk_nxt    = '0;
    trk_nxt[1] = '{kill: 1'b0, bad: bad, wsel: inst_addr[3:2]};
    for (int k = 2; k <= RAM_LAT; k++) begin
      trk_nxt[k]      = trk_pipe[k-1];
      trk_nxt[k].kill = trk_pipe[k-1].kill | inst_cancel;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_pipe <= '0;
      trk_pipe <= '0;
    end else begin
      vld_pipe[1] <= inst_addr_ok;
      for (int k = 2; k <= RAM_LAT; k++) vld_pipe[k] <= vld_pipe[k-1];
      trk_pipe <= trk_nxt;
    end
  end

  assign last = trk_pipe[RAM_LAT];
  assign load = vld_pipe[RAM_LAT] & ~last.kill & ~inst_cancel;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_valid     <= 1'b0;
      inst_rdata     <= '0;
      inst_count     <= '0;
      inst_exception <= 1'b0;
      inst_exccode   <= '0;
    end else begin
      inst_valid <= load;
      if (load) begin
        inst_count     <= 2'd3 - last.wsel;
        inst_exception <= last.bad;
        inst_exccode   <= last.bad ? EXC_ADEF : 6'h00;
        inst_rdata     <= last.bad ? '0 : (ram_rdata >> {last.wsel, 5'b0});
      end
    end
  end

endmodule

// File: tb/tb_cpu7_inst_resp.sv
// Self-checking bench for cpu7_inst_resp: vector table, directed multi-cycle
// sequences and a randomized run against a cycle-indexed response model.
module tb_cpu7_inst_resp;
  localparam int          L    = 2;
  localparam int          AW   = 14;
  localparam logic [31:0] BASE = 32'h1c000000;
  localparam int          MAXC = 4096;

  logic          clk, resetn, inst_req, inst_cancel;
  logic [31:0]   inst_addr;
  logic          inst_addr_ok, inst_valid, inst_uncache, inst_exception, ram_en;
  logic [127:0]  inst_rdata, ram_rdata;
  logic [1:0]    inst_count;
  logic [5:0]    inst_exccode;
  logic [AW-1:0] ram_addr;

  cpu7_inst_resp #(.RAM_LAT(L), .MEM_AW(AW), .MEM_BASE(BASE)) dut (
    .clk(clk), .resetn(resetn), .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_cancel(inst_cancel), .inst_addr_ok(inst_addr_ok), .inst_rdata(inst_rdata),
    .inst_valid(inst_valid), .inst_count(inst_count), .inst_uncache(inst_uncache),
    .inst_exception(inst_exception), .inst_exccode(inst_exccode), .ram_en(ram_en),
    .ram_addr(ram_addr), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] line_of(input int idx);
    logic [127:0] r;
    for (int k = 0; k < 4; k++) r[32*k +: 32] = 32'h5A000000 + 32'(idx*4 + k);
    return r;
  endfunction

  // SRAM: data for a read appears L cycles after ram_en, junk otherwise
  logic [L-1:0]  sr_v;
  logic [AW-1:0] sr_a [L];
  logic [127:0]  junk;
  always @(posedge clk) begin
    for (int k = L-1; k > 0; k--) begin
      sr_v[k] <= sr_v[k-1];
      sr_a[k] <= sr_a[k-1];
    end
    sr_v[0] <= ram_en;
    sr_a[0] <= ram_addr;
    junk    <= {$urandom, $urandom, $urandom, $urandom};
  end
  always_comb ram_rdata = sr_v[L-1] ? line_of(int'(sr_a[L-1])) : junk;

  // Reference model: expected response keyed by the cycle it must appear in
  bit           exp_v [MAXC];
  logic [127:0] exp_d [MAXC];
  logic [1:0]   exp_c [MAXC];
  bit           exp_x [MAXC];
  logic [127:0] held_d;
  logic [1:0]   held_c;
  bit           held_x;
  int cyc, checks, fails, nvld;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d act=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic drive_cycle(input logic req, input logic [31:0] a, input logic cnl);
    longint ua, off;
    bit ok, bad;
    int w, idx, due;
    logic [127:0] ln, d;
    inst_req = req; inst_addr = a; inst_cancel = cnl;
    #1;
    ok  = req && !cnl && resetn;
    ua  = {32'b0, a};
    off = ua - longint'({32'b0, BASE});
    bad = (ua % 4 != 0) || (ua < longint'({32'b0, BASE})) || (off >= (longint'(16) << AW));
    idx = bad ? 0 : int'(off / 16);
    w   = int'((ua / 4) % 4);
    chk("addr_ok", inst_addr_ok, ok);
    chk("ram_en", ram_en, ok && !bad);
    if (ok && !bad) chk("ram_addr", ram_addr, idx);
    if (cnl)
      for (int c = cyc + 1; c <= cyc + L; c++) if (c < MAXC) exp_v[c] = 0;
    due = cyc + L + 1;
    if (ok && due < MAXC) begin
      d = '0;
      if (!bad) begin
        ln = line_of(idx);
        for (int k = 0; k + w < 4; k++) d[32*k +: 32] = ln[32*(k+w) +: 32];
      end
      exp_v[due] = 1; exp_d[due] = d; exp_c[due] = 2'(3 - w); exp_x[due] = bad;
    end
  endtask

  task automatic check_out();
    chk("inst_valid", inst_valid, exp_v[cyc]);
    if (exp_v[cyc]) begin
      held_d = exp_d[cyc]; held_c = exp_c[cyc]; held_x = exp_x[cyc];
    end
    if (inst_valid) nvld++;
    chk("inst_rdata", inst_rdata, held_d);
    chk("inst_count", inst_count, held_c);
    chk("inst_exception", inst_exception, held_x);
    chk("inst_exccode", inst_exccode, held_x ? 6'h08 : 6'h00);
    chk("inst_uncache", inst_uncache, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    if (cyc < MAXC) check_out();
  endtask

  task automatic step(input logic req, input logic [31:0] a, input logic cnl);
    drive_cycle(req, a, cnl);
    tick();
  endtask

  typedef struct {
    logic [31:0]   addr;
    logic          en;
    logic [AW-1:0] ra;
    logic          exc;
    logic [1:0]    cnt;
    logic [127:0]  data;
  } vec_t;

  vec_t vt [7];
  logic [127:0] tmp;
  logic [31:0]  ra32;
  int r, m;

  initial begin
    resetn = 1'b0; inst_req = 1'b1; inst_addr = BASE; inst_cancel = 1'b0;
    cyc = 0; checks = 0; fails = 0; nvld = 0;
    held_d = '0; held_c = '0; held_x = 0;

    vt[0] = '{BASE,                1, 14'd0,      0, 2'd3, line_of(0)};
    tmp = line_of(1);
    vt[1] = '{BASE + 32'h18,       1, 14'd1,      0, 2'd1, {64'h0, tmp[127:64]}};
    vt[2] = '{BASE + 32'h3fff0,    1, 14'h3fff,   0, 2'd3, line_of(16383)};
    vt[3] = '{BASE + 32'h2,        0, 14'd0,      1, 2'd3, 128'h0};
    vt[4] = '{32'h1bfffff0,        0, 14'd0,      1, 2'd3, 128'h0};
    vt[5] = '{BASE + 32'h40000,    0, 14'd0,      1, 2'd3, 128'h0};
    tmp = line_of(2);
    vt[6] = '{BASE + 32'h2c,       1, 14'd2,      0, 2'd0, {96'h0, tmp[127:96]}};

    // Reset state, with a request presented during reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_rdata", inst_rdata, 128'h0);
    chk("rst_count", inst_count, 2'd0);
    chk("rst_exc", inst_exception, 1'b0);
    chk("rst_exccode", inst_exccode, 6'h0);
    chk("rst_addr_ok", inst_addr_ok, 1'b0);
    chk("rst_ram_en", ram_en, 1'b0);
    resetn = 1'b1;

    // Vector table: one isolated fetch each, response at T+L+1
    for (int i = 0; i < 7; i++) begin
      drive_cycle(1'b1, vt[i].addr, 1'b0);
      chk("tv_ram_en", ram_en, vt[i].en);
      if (vt[i].en) chk("tv_ram_addr", ram_addr, vt[i].ra);
      tick();
      repeat (L) step(1'b0, 32'h0, 1'b0);
      chk("tv_valid", inst_valid, 1'b1);
      chk("tv_rdata", inst_rdata, vt[i].data);
      chk("tv_count", inst_count, vt[i].cnt);
      chk("tv_exc", inst_exception, vt[i].exc);
      chk("tv_exccode", inst_exccode, vt[i].exc ? 6'h08 : 6'h00);
    end

    // Streaming: eight back-to-back lines
    nvld = 0;
    for (int i = 0; i < 8; i++) step(1'b1, BASE + 32'(16*i), 1'b0);
    repeat (L + 1) step(1'b0, 32'h0, 1'b0);
    chk("stream_pulses", nvld, 8);

    // Cancel on the third of three requests, then a fresh request
    nvld = 0;
    step(1'b1, BASE + 32'h100, 1'b0);
    step(1'b1, BASE + 32'h110, 1'b0);
    drive_cycle(1'b1, BASE + 32'h120, 1'b1);
    chk("cancel_addr_ok", inst_addr_ok, 1'b0);
    tick();
    step(1'b1, BASE + 32'h134, 1'b0);
    repeat (L + 2) step(1'b0, 32'h0, 1'b0);
    chk("cancel_pulses", nvld, 1);

    // Reset while one response is visible and two are in flight
    step(1'b1, BASE + 32'h200, 1'b0);
    step(1'b1, BASE + 32'h210, 1'b0);
    step(1'b1, BASE + 32'h220, 1'b0);
    chk("pre_rst_valid", inst_valid, 1'b1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_valid", inst_valid, 1'b0);
    chk("mid_rst_rdata", inst_rdata, 128'h0);
    for (int c = cyc; c < MAXC; c++) exp_v[c] = 0;
    held_d = '0; held_c = '0; held_x = 0;
    nvld = 0;
    repeat (2) step(1'b0, 32'h0, 1'b0);
    resetn = 1'b1;
    repeat (L + 4) step(1'b0, 32'h0, 1'b0);
    chk("post_rst_pulses", nvld, 0);

    // Randomized traffic with occasional cancels and bad addresses
    repeat (600) begin
      r = int'($urandom_range(0, 99));
      m = int'($urandom_range(0, 9));
      ra32 = BASE + ($urandom_range(0, (1 << AW) - 1) << 4) + ($urandom_range(0, 3) << 2);
      if (m == 7) ra32 = ra32 | $urandom_range(1, 3);
      else if (m == 8) ra32 = BASE - 32'(4 * $urandom_range(1, 64));
      else if (m == 9) ra32 = BASE + (32'd1 << (AW + 4)) + 32'(4 * $urandom_range(0, 64));
      step(r < 75, ra32, $urandom_range(0, 15) == 0);
    end
    repeat (L + 1) step(1'b0, 32'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
